conv_enc_frame_ctrl: RTL and testbench

//  Frame sequencer for the rate-1/2 convolutional encoder in the PRML/Viterbi path.

---
 rtl/conv_enc_pkg.sv | 34 +++
 rtl/conv_enc_frame_ctrl_sym_buf.sv | 56 +++++
 rtl/conv_enc_frame_ctrl.sv | 124 ++++++++++++
 tb/tb_conv_enc_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_enc_pkg
//  Description : Shared definitions for the convolutional-encoder frame
//                controller: FSM state type, default constraint length and
//                the generator polynomials used by the encoder.
//  Revision    : 1.0  initial release
// ============================================================================
package conv_enc_pkg;

    // Default encoder constraint length; the tail is K-1 zero bits.
    localparam int unsigned K_DEFAULT = 3;

    // Generator polynomials (octal 7 and 5); MSB taps the newest bit.
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    // Frame sequencer state encoding.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_TAIL  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        CLEAR = ST_CLEAR,
        DATA  = ST_DATA,
        TAIL  = ST_TAIL,
        DRAIN = ST_DRAIN
    } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_enc_frame_ctrl_sym_buf.sv
`default_nettype none
// ============================================================================
//  Module      : sym_buf
//  Description : Two-entry code-symbol serialiser. A load captures both
//                symbols {g1,g0} of one encoder shift; g0 leaves first, then
//                g1. Flags the final symbol of the frame.
//  Revision    : 1.0  initial release
// ============================================================================
module sym_buf (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [1:0] sym,
    input  logic       load_last,
    input  logic       out_ready,
    output logic       can_load,
    output logic       out_bit,
    output logic       out_valid,
    output logic       out_last
);

    logic       r_g0;
    logic       r_g1;
    logic [1:0] r_cnt;
    logic       r_last;
    logic       w_consume;

    assign out_valid = (r_cnt != 2'd0);
    assign w_consume = out_valid && out_ready;

    // A load is safe when empty, or when the single remaining symbol leaves this cycle.
    assign can_load  = (r_cnt == 2'd0) || ((r_cnt == 2'd1) && out_ready);

    // Head of the buffer: g0 while both are held, g1 once g0 has gone.
    assign out_bit   = out_valid && ((r_cnt == 2'd2) ? r_g0 : r_g1);
    assign out_last  = (r_cnt == 2'd1) && r_last;

    // Load overwrites both entries; otherwise a handshake pops one symbol.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_g0   <= 1'b0;
            r_g1   <= 1'b0;
            r_cnt  <= 2'd0;
            r_last <= 1'b0;
        end else if (load) begin
            r_g0   <= sym[0];
            r_g1   <= sym[1];
            r_cnt  <= 2'd2;
            r_last <= load_last;
        end else if (w_consume) begin
            r_cnt  <= r_cnt - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_enc_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv_enc_frame_ctrl
//  Description : Frame sequencer for the rate-1/2 convolutional encoder.
//                Clears the encoder, feeds frame_len data bits then K-1 zero
//                tail bits, and serialises the code symbols one per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_enc_frame_ctrl
    import conv_enc_pkg::*;
#(
    parameter int unsigned K     = K_DEFAULT,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             enc_clear,
    output logic             enc_shift,
    output logic             enc_bit,
    input  logic [1:0]       enc_sym,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int TW = $clog2(K);

    state_t           r_state;
    logic [LEN_W-1:0] r_remain;
    logic [TW-1:0]    r_tail;
    logic             r_done;

    logic w_can_shift;
    logic w_take;
    logic w_tail_shift;
    logic w_last_tail;
    logic w_out_last;
    logic w_final_hs;

    assign w_take       = (r_state == DATA) && in_valid && w_can_shift;
    assign w_tail_shift = (r_state == TAIL) && w_can_shift;
    assign w_last_tail  = w_tail_shift && (r_tail == TW'(K - 2));
    // Only g1 of the last tail shift carries the last flag, so this is the frame's final handshake.
    assign w_final_hs   = (r_state == DRAIN) && w_out_last && out_ready;

    assign in_ready  = (r_state == DATA) && w_can_shift;
    assign enc_clear = (r_state == CLEAR);
    assign enc_shift = w_take || w_tail_shift;
    assign enc_bit   = (r_state == DATA) && in_bit;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign out_last  = w_out_last;

    // Frame sequencing: state, remaining data bits and tail shifts issued.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_remain <= '0;
            r_tail   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_remain <= frame_len;
                        r_state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_tail  <= '0;
                    r_state <= (r_remain == '0) ? TAIL : DATA;
                end
                DATA: begin
                    if (w_take) begin
                        r_remain <= r_remain - LEN_W'(1);
                        if (r_remain == LEN_W'(1)) begin
                            r_state <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    if (w_tail_shift) begin
                        if (w_last_tail) begin
                            r_state <= DRAIN;
                        end else begin
                            r_tail <= r_tail + TW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_final_hs) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sym_buf u_sym_buf (
        .clock     (clock),
        .reset     (reset),
        .load      (enc_shift),
        .sym       (enc_sym),
        .load_last (w_last_tail),
        .out_ready (out_ready),
        .can_load  (w_can_shift),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_last  (w_out_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_conv_enc_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_enc_frame_ctrl
//  Description : Self-checking bench for conv_enc_frame_ctrl with an encoder
//                stub (G0=7, G1=5 octal) and a convolution reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_enc_frame_ctrl;
    import conv_enc_pkg::*;

    localparam int LEN_W = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic             in_bit = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             enc_clear;
    logic             enc_shift;
    logic             enc_bit;
    logic [1:0]       enc_sym;
    logic             out_bit;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_last;
    logic             busy;
    logic             done;

    conv_enc_frame_ctrl #(.K(3), .LEN_W(LEN_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .frame_len (frame_len),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .enc_clear (enc_clear),
        .enc_shift (enc_shift),
        .enc_bit   (enc_bit),
        .enc_sym   (enc_sym),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Encoder stub; starts non-zero so a missing clear is visible.
    logic [1:0] enc_sr = 2'b11;
    logic [2:0] enc_win;
    always @(posedge clock) begin
        if (enc_clear)      enc_sr <= 2'b00;
        else if (enc_shift) enc_sr <= {enc_sr[0], enc_bit};
    end
    always_comb begin
        enc_win = {enc_bit, enc_sr[0], enc_sr[1]};
        enc_sym = {^(enc_win & G1), ^(enc_win & G0)};
    end

    // Monitor: cycle count, handshakes and protocol observations.
    int cyc = 0;
    always @(posedge clock) cyc++;

    logic q_bits[$];
    logic q_last[$];
    int occ = 0;
    int viol_shift = 0, viol_valid = 0, n_in_ready = 0, n_clear = 0, n_done = 0;
    int start_cyc = -1, first_shift_cyc = -1, first_valid_cyc = -1;
    int last_hs_cyc = -1, done_cyc = -1;
    always @(negedge clock) begin
        if (reset) begin
            occ = 0;
        end else begin
            if (out_valid !== (occ != 0)) viol_valid++;
            if (enc_shift && !(occ == 0 || (occ == 1 && out_ready))) viol_shift++;
            if (in_ready) n_in_ready++;
            if (enc_clear) n_clear++;
            if (start && !busy) begin
                start_cyc = cyc; first_shift_cyc = -1; first_valid_cyc = -1;
            end
            if (enc_shift && first_shift_cyc < 0) first_shift_cyc = cyc;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                q_bits.push_back(out_bit);
                q_last.push_back(out_last);
                last_hs_cyc = cyc;
            end
            if (done) begin n_done++; done_cyc = cyc; end
            occ = occ - ((out_valid && out_ready) ? 1 : 0) + (enc_shift ? 2 : 0);
        end
    end

    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: direct convolution of the frame (data then K-1 zeros).
    bit   din[64];
    logic exp_q[$];
    function automatic void build_exp(input int len);
        exp_q.delete();
        for (int i = 0; i < len + K_DEFAULT - 1; i++) begin
            bit s0 = 0, s1 = 0;
            for (int j = 0; j < K_DEFAULT; j++) begin
                bit x = (i - j >= 0 && i - j < len) ? din[i - j] : 1'b0;
                s0 ^= x & G0[K_DEFAULT - 1 - j];
                s1 ^= x & G1[K_DEFAULT - 1 - j];
            end
            exp_q.push_back(s0);
            exp_q.push_back(s1);
        end
    endfunction

    int fbase;

    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    // gap: idle cycles on in_valid after each accepted bit; negative = random.
    task automatic run_frame(input string tag, input int len, input int rdy_mode,
                             input int gap, input bit poke, input int abort_at);
        int  idx = 0, gcnt = 0, k = 0;
        int  dbase = n_done, vs = viol_shift, vv = viol_valid;
        int  irb = n_in_ready, clb = n_clear;
        bit  took, aborted = 0, finished = 0;
        int  nlast = 0, last_idx = -1, nsym;
        fbase = q_bits.size();
        build_exp(len);
        start = 1'b1; frame_len = LEN_W'(len);
        in_valid = (len > 0); in_bit = din[0]; out_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; frame_len = LEN_W'($urandom);
        for (k = 0; k < 3000; k++) begin
            if (abort_at > 0 && (q_bits.size() - fbase) >= abort_at) begin
                reset = 1'b1; #1;
                chk({tag, "_abort_outs"},
                    {in_ready, enc_clear, enc_shift, enc_bit, out_bit, out_valid, out_last, busy, done}, 0);
                repeat (3) @(posedge clock);
                #1 reset = 1'b0; in_valid = 1'b0;
                repeat (4) @(posedge clock);
                #1;
                chk({tag, "_abort_nodone"}, n_done - dbase, 0);
                chk({tag, "_abort_idle"}, busy, 0);
                aborted = 1;
                break;
            end
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 4 == 0) || (k % 4 == 3);
                default: out_ready = ($urandom % 4) != 0;
            endcase
            if (idx < len) begin
                in_valid = (gap < 0) ? 1'($urandom) : (gcnt == 0);
                in_bit   = din[idx];
            end else begin
                in_valid = 1'($urandom);
                in_bit   = 1'($urandom);
            end
            start = poke && (k == 4 || k == 9);
            if (start) frame_len = LEN_W'($urandom);
            @(negedge clock);
            took = in_valid && in_ready;
            @(posedge clock); #1;
            if (took) begin idx++; gcnt = gap; end
            else if (gcnt > 0) gcnt--;
            if (done) begin finished = 1; break; end
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        if (aborted) return;
        chk({tag, "_finished"}, finished, 1);
        @(posedge clock); #1;
        chk({tag, "_done_1cyc"}, done, 0);
        nsym = q_bits.size() - fbase;
        chk({tag, "_nsym"}, nsym, exp_q.size());
        for (int i = 0; i < nsym && i < exp_q.size(); i++)
            chk($sformatf("%s_sym%0d", tag, i), q_bits[fbase + i], exp_q[i]);
        for (int i = 0; i < nsym; i++)
            if (q_last[fbase + i]) begin nlast++; last_idx = i; end
        chk({tag, "_nlast"}, nlast, 1);
        chk({tag, "_last_idx"}, last_idx, exp_q.size() - 1);
        chk({tag, "_ndone"}, n_done - dbase, 1);
        chk({tag, "_done_lat"}, done_cyc - last_hs_cyc, 1);
        chk({tag, "_shift_full"}, viol_shift - vs, 0);
        chk({tag, "_valid_gap"}, viol_valid - vv, 0);
        chk({tag, "_nclear"}, n_clear - clb, 1);
        chk({tag, "_shift_to_g0"}, first_valid_cyc - first_shift_cyc, 1);
        if (gap >= 0) chk({tag, "_start_to_shift"}, first_shift_cyc - start_cyc, 2);
        if (len == 0) chk({tag, "_no_in_ready"}, n_in_ready - irb, 0);
    endtask

    task automatic case1_bits();
        din[0] = 1; din[1] = 0; din[2] = 1; din[3] = 1;
    endtask

    task automatic chk_case1_literal(input string tag);
        logic [11:0] got = '0;
        logic [11:0] want;
        want = 12'b11_10_00_01_01_11;
        for (int i = 0; i < 12; i++)
            if (fbase + i < q_bits.size()) got[11 - i] = q_bits[fbase + i];
        chk(tag, got, want);
    endtask

    initial begin
        int len;
        // Reset state
        #1;
        chk("reset_outs",
            {in_ready, enc_clear, enc_shift, enc_bit, out_bit, out_valid, out_last, busy, done}, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        chk("idle_busy", busy, 0);

        // Case 1: basic 4-bit frame
        case1_bits();
        run_frame("c1", 4, 0, 0, 0, 0);
        chk_case1_literal("c1_literal");

        // Case 2: tail-only frame
        run_frame("c2", 0, 0, 0, 0, 0);

        // Case 3: downstream stalls
        case1_bits();
        run_frame("c3", 4, 1, 0, 0, 0);
        chk_case1_literal("c3_literal");

        // Case 4: input gaps
        case1_bits();
        run_frame("c4", 4, 0, 3, 0, 0);
        chk_case1_literal("c4_literal");

        // Case 5: start and frame_len pokes while busy
        for (int i = 0; i < 12; i++) din[i] = 1'($urandom);
        run_frame("c5", 12, 2, 0, 1, 0);

        // Case 6: abort after third symbol, then clean case-1 frame
        case1_bits();
        run_frame("c6a", 4, 0, 0, 0, 3);
        case1_bits();
        run_frame("c6b", 4, 0, 0, 0, 0);
        chk_case1_literal("c6b_literal");

        // Single-bit frame and randomized frames
        din[0] = 1;
        run_frame("len1", 1, 2, 0, 0, 0);
        for (int f = 0; f < 4; f++) begin
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) din[i] = 1'($urandom);
            run_frame($sformatf("rnd%0d", f), len, 2, -1, f[0], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
